// File: rtl/fp_pkg.sv
// Shared definitions for the FP multiply scheduler: FSM states and parameter defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fp_pkg;

  // Default operand/result width (IEEE-754 binary32) and acceptance-to-result latency.
  localparam int FP_N_DEFAULT   = 32;
  localparam int FP_LAT_DEFAULT = 2;

  // Scheduler FSM: one operation in flight at a time.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } sched_state_e;

  // Exponent field width for a supported IEEE-754 format (binary32 or binary64).
  function automatic int fp_exp_width(input int n);
    return (n == 64) ? 11 : 8;
  endfunction

endpackage

// File: rtl/fp_mul_scheduler_fp_multiplier.sv
// FP_Multiplier: combinational IEEE-754 multiply, round-to-nearest-even, full denormal support.
// Latency: 0 cycles (pure combinational; the caller registers inputs and result).
// Backpressure: none.
//
// Ports:
//   a_i, b_i : N-bit IEEE-754 operands
//   p_o      : N-bit IEEE-754 product
// Any NaN operand or Inf*0 yields the canonical quiet NaN; overflow saturates to signed Inf.
module FP_Multiplier
  import fp_pkg::*;
#(
  parameter int N = FP_N_DEFAULT
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] p_o
);

  localparam int EW   = fp_exp_width(N);
  localparam int MW   = N - 1 - EW;       // stored mantissa bits
  localparam int SW   = MW + 1;           // significand incl. hidden bit
  localparam int PW   = 2 * SW;           // full product width
  localparam int MAGW = N - 1;            // exponent + mantissa field
  localparam int BIAS = (1 << (EW - 1)) - 1;
  localparam int EMAX = (1 << EW) - 1;

  logic                s_p;
  logic [EW-1:0]       ea, eb, ea_eff, eb_eff, e_fin;
  logic [MW-1:0]       ma, mb;
  logic [SW-1:0]       sig_a, sig_b;
  logic [PW-1:0]       prod, norm;
  logic signed [15:0]  exp_sum, exp_r, lead, lz, shamt;
  logic                a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic                ovf, guard, sticky, sticky_sh, inc;
  logic [MAGW-1:0]     mag, mag_rnd;

  always_comb begin
    ea     = a_i[N-2 -: EW];
    eb     = b_i[N-2 -: EW];
    ma     = a_i[MW-1:0];
    mb     = b_i[MW-1:0];
    s_p    = a_i[N-1] ^ b_i[N-1];

    a_nan  = (ea == EW'(EMAX)) && (ma != '0);
    b_nan  = (eb == EW'(EMAX)) && (mb != '0);
    a_inf  = (ea == EW'(EMAX)) && (ma == '0);
    b_inf  = (eb == EW'(EMAX)) && (mb == '0);
    a_zero = (ea == '0) && (ma == '0);
    b_zero = (eb == '0) && (mb == '0);

    // Denormals: hidden bit 0 and effective exponent 1.
    ea_eff = (ea == '0) ? EW'(1) : ea;
    eb_eff = (eb == '0) ? EW'(1) : eb;
    sig_a  = {(ea != '0), ma};
    sig_b  = {(eb != '0), mb};
    prod   = PW'(sig_a) * PW'(sig_b);

    // Biased exponent of the product when its binary point sits below bit PW-2.
    exp_sum = 16'(ea_eff) + 16'(eb_eff) - 16'(BIAS);

    // Leading-one position; denormal operands can push it well below the top.
    lead = '0;
    for (int i = 0; i < PW; i++) begin
      if (prod[i]) lead = 16'(i);
    end
    lz    = 16'(PW - 1) - lead;
    norm  = prod << lz;
    exp_r = exp_sum + 16'sd1 - lz;
    ovf   = (exp_r >= $signed(16'(EMAX)));

    // Results below the normal range are shifted into denormal form; shifted-out bits
    // feed the sticky bit so rounding stays correct.
    sticky_sh = 1'b0;
    shamt     = '0;
    e_fin     = '0;
    if (exp_r < 16'sd1) begin
      shamt = 16'sd1 - exp_r;
      for (int i = 0; i < PW; i++) begin
        if (($signed(16'(i)) < shamt) && norm[i]) sticky_sh = 1'b1;
      end
      norm = norm >> shamt;
    end else begin
      e_fin = exp_r[EW-1:0];
    end

    guard   = norm[PW-2-MW];
    sticky  = (|norm[PW-3-MW:0]) | sticky_sh;
    mag     = {e_fin, norm[PW-2 -: MW]};
    inc     = guard & (sticky | mag[0]);
    // Mantissa carry ripples into the exponent (denormal->normal, max->Inf).
    mag_rnd = mag + MAGW'(inc);

    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      p_o = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
    end else if (a_inf || b_inf || (ovf && !a_zero && !b_zero)) begin
      p_o = {s_p, {EW{1'b1}}, {MW{1'b0}}};
    end else if (a_zero || b_zero) begin
      p_o = {s_p, {(N-1){1'b0}}};
    end else begin
      p_o = {s_p, mag_rnd};
    end
  end

endmodule

// File: rtl/fp_mul_scheduler.sv
// Two-requester scheduler sharing one FP multiplier; round-robin on ties, one op in flight.
// Latency: result valid LAT edges after acceptance; held until the owning requester consumes it.
// Backpressure: reqi_ready only in IDLE; a stalled response blocks all new requests.
//
// Ports:
//   clk, rst                  : clock, async active-high reset
//   reqi_valid/ready, reqi_a/b: request handshake and operands, i = 0/1
//   rspi_valid/ready          : response handshake, i = 0/1
//   rsp_result                : product, meaningful while any rspi_valid is high
//   busy, grant_id            : FSM not idle; owner of current/last operation
//   ops0_cnt, ops1_cnt        : completed responses per requester (only with FP_SCHED_STATS_EN)
// Optional feature macro: FP_SCHED_STATS_EN. N must be 32 or 64; LAT must be >= 1.
module fp_mul_scheduler
  import fp_pkg::*;
#(
  parameter int N   = FP_N_DEFAULT,
  parameter int LAT = FP_LAT_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [N-1:0] rsp_result,
  output logic         busy,
  output logic         grant_id
`ifdef FP_SCHED_STATS_EN
  ,
  output logic [15:0]  ops0_cnt,
  output logic [15:0]  ops1_cnt
`endif
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  sched_state_e  state_q;
  logic [CW-1:0] cnt_q;
  logic [N-1:0]  op_a_q, op_b_q, rsp_result_q;
  logic [N-1:0]  op_a_d, op_b_d, mul_p;
  logic          rsp0_valid_q, rsp1_valid_q, busy_q, grant_id_q;
  logic          rr_ptr_q;     // requester that wins the next tie
  logic          idle, sel, accept, rsp0_hs, rsp1_hs, rsp_hs;

  // Ready is gated by rst so it drops the instant reset asserts.
  assign idle = (state_q == IDLE) && !rst;

  // Arbitration: a lone valid requester always wins; ties go to the round-robin pointer.
  always_comb begin
    sel = 1'b0;
    if (req0_valid && req1_valid) begin
      sel = rr_ptr_q;
    end else if (req1_valid) begin
      sel = 1'b1;
    end
  end

  assign req0_ready = idle && req0_valid && !sel;
  assign req1_ready = idle && req1_valid &&  sel;
  assign accept     = req0_ready || req1_ready;

  assign op_a_d = sel ? req1_a : req0_a;
  assign op_b_d = sel ? req1_b : req0_b;

  // A ready from the requester that does not own the response is ignored.
  assign rsp0_hs = rsp0_valid_q && rsp0_ready;
  assign rsp1_hs = rsp1_valid_q && rsp1_ready;
  assign rsp_hs  = rsp0_hs || rsp1_hs;

  // Operands are registered at acceptance, so the multiplier sees stable inputs for
  // the whole WAIT phase regardless of what requesters do afterwards.
  FP_Multiplier #(
    .N(N)
  ) u_mul (
    .a_i(op_a_q),
    .b_i(op_b_q),
    .p_o(mul_p)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      rsp_result_q <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      grant_id_q   <= 1'b0;
      rr_ptr_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            grant_id_q <= sel;
            rr_ptr_q   <= ~sel;
            cnt_q      <= CW'(LAT - 1);
            busy_q     <= 1'b1;
            state_q    <= WAIT;
          end
        end
        WAIT: begin
          // Counter starts at LAT-1, so capture lands exactly LAT edges after acceptance.
          if (cnt_q == '0) begin
            rsp_result_q <= mul_p;
            rsp0_valid_q <= ~grant_id_q;
            rsp1_valid_q <=  grant_id_q;
            state_q      <= DONE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        DONE: begin
          if (rsp_hs) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp_result = rsp_result_q;
  assign busy       = busy_q;
  assign grant_id   = grant_id_q;

`ifdef FP_SCHED_STATS_EN
  logic [15:0] ops0_cnt_q, ops1_cnt_q;

  // Free-running wrap-around counters of consumed responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ops0_cnt_q <= '0;
      ops1_cnt_q <= '0;
    end else begin
      if (rsp0_hs) ops0_cnt_q <= ops0_cnt_q + 16'd1;
      if (rsp1_hs) ops1_cnt_q <= ops1_cnt_q + 16'd1;
    end
  end

  assign ops0_cnt = ops0_cnt_q;
  assign ops1_cnt = ops1_cnt_q;
`endif

endmodule
